// File: rtl/enemy_bullet_pool.sv
// Pool of N_CH independent enemy bullets: launch handshake, per-tick fall, off-screen retire, player hit.
// Optional FIRE_COOLDOWN_EN: a retired channel stays locked for COOLDOWN ticks before it can relaunch.
module enemy_bullet_pool #(
  parameter int N_CH     = 7,
  parameter int X_W      = 10,
  parameter int Y_W      = 9,
  parameter int SPEED    = 4,
  parameter int Y_MAX    = 480,
  parameter int HIT_W    = 16,
`ifdef FIRE_COOLDOWN_EN
  parameter int HIT_H    = 8,
  parameter int COOLDOWN = 15
`else
  parameter int HIT_H    = 8
`endif
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic                  tick,
  input  logic                  clear,
  input  logic [N_CH-1:0]       fire_req,
  output logic [N_CH-1:0]       fire_ack,
  input  logic [N_CH*X_W-1:0]   enemy_x,
  input  logic [N_CH*Y_W-1:0]   enemy_y,
  input  logic [X_W-1:0]        player_x,
  input  logic [Y_W-1:0]        player_y,
  output logic [N_CH-1:0]       active,
  output logic [N_CH*X_W-1:0]   bullet_x,
  output logic [N_CH*Y_W-1:0]   bullet_y,
  output logic                  hit,
  output logic [N_CH-1:0]       hit_mask
);

  typedef enum logic {IDLE = 1'b0, FLY = 1'b1} ch_state_e;

  localparam logic [Y_W:0]          SPEED_V = (Y_W+1)'(SPEED);
  localparam logic [Y_W:0]          Y_MAX_V = (Y_W+1)'(Y_MAX);
  localparam logic signed [X_W:0]   HIT_W_S = (X_W+1)'(HIT_W);
  localparam logic signed [Y_W+1:0] HIT_H_S = (Y_W+2)'(HIT_H);
`ifdef FIRE_COOLDOWN_EN
  localparam int              CD_W    = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN);
`endif

  logic [N_CH-1:0] hm_d_all;
  logic            hit_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    ch_state_e              state_q, state_d;
    logic [X_W-1:0]         x_q, x_d;
    logic [Y_W-1:0]         y_q, y_d;
    logic                   ack_q, ack_d;
    logic                   hm_q, hm_d;
    logic [Y_W:0]           ny;
    logic signed [X_W:0]    dx;
    logic signed [Y_W+1:0]  dy;
    logic                   on_target;
    logic                   locked;
`ifdef FIRE_COOLDOWN_EN
    logic [CD_W-1:0]        cd_q, cd_d;
    assign locked = (cd_q != '0);
`else
    assign locked = 1'b0;
`endif

    // ny is one bit wider than y so a bullet near the bottom cannot wrap to the top
    assign ny        = {1'b0, y_q} + SPEED_V;
    assign dx        = $signed({1'b0, x_q}) - $signed({1'b0, player_x});
    assign dy        = $signed({1'b0, ny}) - $signed({2'b00, player_y});
    assign on_target = (dx <= HIT_W_S) && (dx >= -HIT_W_S) &&
                       (dy <= HIT_H_S) && (dy >= -HIT_H_S);

    always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      ack_d   = 1'b0;
      hm_d    = 1'b0;
`ifdef FIRE_COOLDOWN_EN
      cd_d    = cd_q;
      if (tick && locked) cd_d = cd_q - CD_W'(1);
`endif
      if (clear) begin
        state_d = IDLE;
        x_d     = '0;
        y_d     = '0;
`ifdef FIRE_COOLDOWN_EN
        cd_d    = '0;
`endif
      end else if (state_q == IDLE) begin
        if (fire_req[i] && !locked) begin
          state_d = FLY;
          x_d     = enemy_x[i*X_W +: X_W];
          y_d     = enemy_y[i*Y_W +: Y_W];
          ack_d   = 1'b1;
        end
      end else if (tick) begin
        if ((ny >= Y_MAX_V) || on_target) begin
          state_d = IDLE;
          x_d     = '0;
          y_d     = '0;
          hm_d    = (ny < Y_MAX_V);
`ifdef FIRE_COOLDOWN_EN
          cd_d    = CD_LOAD;
`endif
        end else begin
          y_d = ny[Y_W-1:0];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (RST) begin
        state_q <= IDLE;
        x_q     <= '0;
        y_q     <= '0;
        ack_q   <= 1'b0;
        hm_q    <= 1'b0;
`ifdef FIRE_COOLDOWN_EN
        cd_q    <= '0;
`endif
      end else begin
        state_q <= state_d;
        x_q     <= x_d;
        y_q     <= y_d;
        ack_q   <= ack_d;
        hm_q    <= hm_d;
`ifdef FIRE_COOLDOWN_EN
        cd_q    <= cd_d;
`endif
      end
    end

    assign hm_d_all[i]              = hm_d;
    assign active[i]                = (state_q == FLY);
    assign fire_ack[i]              = ack_q;
    assign hit_mask[i]              = hm_q;
    assign bullet_x[i*X_W +: X_W]   = x_q;
    assign bullet_y[i*Y_W +: Y_W]   = y_q;
  end

  always_ff @(posedge clk) begin
    if (RST) hit_q <= 1'b0;
    else     hit_q <= |hm_d_all;
  end

  assign hit = hit_q;

endmodule

// File: tb/tb_enemy_bullet_pool.sv
// Bench for enemy_bullet_pool: fixed vector table, directed multi-cycle sequences, random run vs reference model.
// Build with FIRE_COOLDOWN_EN defined to exercise the cooldown lock (COOLDOWN overridden to 3).
module tb_enemy_bullet_pool;
  localparam int N_CH = 7, X_W = 10, Y_W = 9, SPEED = 4, Y_MAX = 480, HIT_W = 16, HIT_H = 8;
`ifdef FIRE_COOLDOWN_EN
  localparam int CD = 3;
`else
  localparam int CD = 0;
`endif

  logic                clk = 1'b0;
  logic                RST, tick, clear;
  logic [N_CH-1:0]     fire_req, fire_ack, active, hit_mask;
  logic [N_CH*X_W-1:0] enemy_x, bullet_x;
  logic [N_CH*Y_W-1:0] enemy_y, bullet_y;
  logic [X_W-1:0]      player_x;
  logic [Y_W-1:0]      player_y;
  logic                hit;

  enemy_bullet_pool #(
    .N_CH(N_CH), .X_W(X_W), .Y_W(Y_W), .SPEED(SPEED), .Y_MAX(Y_MAX), .HIT_W(HIT_W),
`ifdef FIRE_COOLDOWN_EN
    .HIT_H(HIT_H), .COOLDOWN(CD)
`else
    .HIT_H(HIT_H)
`endif
  ) dut (
    .clk(clk), .RST(RST), .tick(tick), .clear(clear),
    .fire_req(fire_req), .fire_ack(fire_ack),
    .enemy_x(enemy_x), .enemy_y(enemy_y),
    .player_x(player_x), .player_y(player_y),
    .active(active), .bullet_x(bullet_x), .bullet_y(bullet_y),
    .hit(hit), .hit_mask(hit_mask)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // reference model: per-channel state as plain integers
  int m_act[N_CH], m_x[N_CH], m_y[N_CH], m_cd[N_CH];
  logic [N_CH-1:0] m_ack, m_hm;
  logic m_hit;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_step();
    int ny, cd_old;
    logic [N_CH-1:0] hm;
    if (RST) begin
      for (int i = 0; i < N_CH; i++) begin
        m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; m_cd[i] = 0;
      end
      m_ack = '0; m_hm = '0; m_hit = 1'b0;
    end else begin
      hm = '0;
      for (int i = 0; i < N_CH; i++) begin
        cd_old = m_cd[i];
        m_ack[i] = 1'b0;
        if (tick && m_cd[i] > 0) m_cd[i] = m_cd[i] - 1;
        if (clear) begin
          m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; m_cd[i] = 0;
        end else if (m_act[i] == 0) begin
          if (fire_req[i] && cd_old == 0) begin
            m_act[i] = 1;
            m_x[i] = int'(enemy_x[i*X_W +: X_W]);
            m_y[i] = int'(enemy_y[i*Y_W +: Y_W]);
            m_ack[i] = 1'b1;
          end
        end else if (tick) begin
          ny = m_y[i] + SPEED;
          if (ny >= Y_MAX || (iabs(m_x[i] - int'(player_x)) <= HIT_W &&
                              iabs(ny - int'(player_y)) <= HIT_H)) begin
            hm[i] = (ny < Y_MAX);
            m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; m_cd[i] = CD;
          end else begin
            m_y[i] = ny;
          end
        end
      end
      m_hm = hm;
      m_hit = |hm;
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model();
    logic [N_CH*X_W-1:0] ex;
    logic [N_CH*Y_W-1:0] ey;
    logic [N_CH-1:0] ea;
    for (int i = 0; i < N_CH; i++) begin
      ex[i*X_W +: X_W] = X_W'(m_x[i]);
      ey[i*Y_W +: Y_W] = Y_W'(m_y[i]);
      ea[i] = (m_act[i] != 0);
    end
    chk("rnd_active", 128'(active), 128'(ea));
    chk("rnd_fire_ack", 128'(fire_ack), 128'(m_ack));
    chk("rnd_hit", 128'(hit), 128'(m_hit));
    chk("rnd_hit_mask", 128'(hit_mask), 128'(m_hm));
    chk("rnd_bullet_x", 128'(bullet_x), 128'(ex));
    chk("rnd_bullet_y", 128'(bullet_y), 128'(ey));
  endtask

  task automatic set_enemy(input int ch, input int x, input int y);
    enemy_x[ch*X_W +: X_W] = X_W'(x);
    enemy_y[ch*Y_W +: Y_W] = Y_W'(y);
  endtask

  typedef struct {
    logic rst, tk, clr;
    logic [N_CH-1:0] fire;
    logic [N_CH-1:0] e_act, e_ack;
    logic e_hit;
    logic [N_CH-1:0] e_hm;
    int e_y0;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic tk, input logic clr, input logic [N_CH-1:0] fire,
                              input logic [N_CH-1:0] e_act, input logic [N_CH-1:0] e_ack, input logic e_hit,
                              input logic [N_CH-1:0] e_hm, input int e_y0);
    vec_t v;
    v.rst = rst; v.tk = tk; v.clr = clr; v.fire = fire;
    v.e_act = e_act; v.e_ack = e_ack; v.e_hit = e_hit; v.e_hm = e_hm; v.e_y0 = e_y0;
    return v;
  endfunction

  vec_t tbl[13];

  initial begin
    // player at (320,440); ch0 falls from 460 to off-screen, ch2 from (330,420) into the player
    tbl[0]  = mk(1, 0, 0, 7'h7F, 7'h00, 7'h00, 0, 7'h00, 0);
    tbl[1]  = mk(1, 0, 0, 7'h7F, 7'h00, 7'h00, 0, 7'h00, 0);
    tbl[2]  = mk(0, 0, 0, 7'h7F, 7'h7F, 7'h7F, 0, 7'h00, 460);
    tbl[3]  = mk(0, 0, 0, 7'h7F, 7'h7F, 7'h00, 0, 7'h00, 460);
    tbl[4]  = mk(0, 0, 1, 7'h00, 7'h00, 7'h00, 0, 7'h00, 0);
    tbl[5]  = mk(0, 0, 0, 7'h05, 7'h05, 7'h05, 0, 7'h00, 460);
    tbl[6]  = mk(0, 1, 0, 7'h00, 7'h05, 7'h00, 0, 7'h00, 464);
    tbl[7]  = mk(0, 0, 0, 7'h00, 7'h05, 7'h00, 0, 7'h00, 464);
    tbl[8]  = mk(0, 1, 0, 7'h00, 7'h05, 7'h00, 0, 7'h00, 468);
    tbl[9]  = mk(0, 1, 0, 7'h00, 7'h01, 7'h00, 1, 7'h04, 472);  // ny=432, |432-440|=8 is on the edge of the box
    tbl[10] = mk(0, 0, 0, 7'h00, 7'h01, 7'h00, 0, 7'h00, 472);
    tbl[11] = mk(0, 1, 0, 7'h00, 7'h01, 7'h00, 0, 7'h00, 476);
    tbl[12] = mk(0, 1, 0, 7'h00, 7'h00, 7'h00, 0, 7'h00, 0);

    RST = 1'b1; tick = 1'b0; clear = 1'b0; fire_req = '0;
    enemy_x = '0; enemy_y = '0;
    player_x = 10'd320; player_y = 9'd440;
    for (int i = 0; i < N_CH; i++) set_enemy(i, 600, 0);
    set_enemy(0, 100, 460);
    set_enemy(2, 330, 420);

    for (int r = 0; r < 13; r++) begin
      RST = tbl[r].rst; tick = tbl[r].tk; clear = tbl[r].clr; fire_req = tbl[r].fire;
      step();
      chk($sformatf("tbl%0d_active", r), 128'(active), 128'(tbl[r].e_act));
      chk($sformatf("tbl%0d_ack", r), 128'(fire_ack), 128'(tbl[r].e_ack));
      chk($sformatf("tbl%0d_hit", r), 128'(hit), 128'(tbl[r].e_hit));
      chk($sformatf("tbl%0d_hit_mask", r), 128'(hit_mask), 128'(tbl[r].e_hm));
      chk($sformatf("tbl%0d_y0", r), 128'(bullet_y[Y_W-1:0]), 128'(tbl[r].e_y0));
    end
    tick = 1'b0; fire_req = '0;

    // two channels hitting on the same tick, while ch5 launches on that tick
    clear = 1'b1; step(); clear = 1'b0;
    set_enemy(1, 310, 420); set_enemy(3, 335, 420); set_enemy(5, 50, 100);
    fire_req = 7'h0A; step();
    chk("mh_launch_ack", 128'(fire_ack), 128'h0A);
    fire_req = '0; tick = 1'b1; step(); step();
    chk("mh_no_early_hit", 128'(hit), 128'h0);
    fire_req = 7'h20; step();
    chk("mh_hit", 128'(hit), 128'h1);
    chk("mh_hit_mask", 128'(hit_mask), 128'h0A);
    chk("mh_active", 128'(active), 128'h20);
    chk("mh_ack5", 128'(fire_ack), 128'h20);
    chk("mh_y5_unmoved", 128'(bullet_y[5*Y_W +: Y_W]), 128'd100);
    fire_req = '0; tick = 1'b0; step();
    chk("mh_hit_drop", 128'(hit), 128'h0);
    chk("mh_mask_drop", 128'(hit_mask), 128'h0);
    tick = 1'b1; step(); tick = 1'b0;
    chk("mh_y5_moved", 128'(bullet_y[5*Y_W +: Y_W]), 128'd104);

    // clear together with tick while four bullets fly
    for (int i = 0; i < N_CH; i++) set_enemy(i, 600, 0);
    clear = 1'b1; step(); clear = 1'b0;
    fire_req = 7'h55; step(); fire_req = '0;
    tick = 1'b1; step();
    chk("clr_pre_active", 128'(active), 128'h55);
    clear = 1'b1; step(); clear = 1'b0; tick = 1'b0;
    chk("clr_active", 128'(active), 128'h0);
    chk("clr_hit", 128'(hit), 128'h0);
    chk("clr_bullet_y", 128'(bullet_y), 128'h0);
    fire_req = 7'h55; step();
    chk("clr_relaunch_ack", 128'(fire_ack), 128'h55);
    chk("clr_relaunch_active", 128'(active), 128'h55);
    fire_req = '0;

    // relaunch after an off-screen retire with fire_req held high
    clear = 1'b1; step(); clear = 1'b0;
    set_enemy(0, 600, 476);
    fire_req = 7'h01; step();
    chk("cd_launch_ack", 128'(fire_ack), 128'h01);
    tick = 1'b1; step(); tick = 1'b0;
    chk("cd_retire_active", 128'(active), 128'h0);
    chk("cd_retire_hit", 128'(hit), 128'h0);
`ifdef FIRE_COOLDOWN_EN
    step();
    chk("cd_locked0", 128'(fire_ack), 128'h0);
    for (int k = 1; k <= CD; k++) begin
      tick = 1'b1; step(); tick = 1'b0;
      chk($sformatf("cd_locked_tick%0d", k), 128'(fire_ack), 128'h0);
      if (k < CD) begin
        step();
        chk($sformatf("cd_locked_gap%0d", k), 128'(fire_ack), 128'h0);
      end
    end
    step();
    chk("cd_unlock_ack", 128'(fire_ack), 128'h01);
`else
    step();
    chk("relaunch_ack", 128'(fire_ack), 128'h01);
`endif
    fire_req = '0;

    // random traffic against the reference model
    RST = 1'b1; step(); RST = 1'b0;
    check_model();
    for (int c = 0; c < 3000; c++) begin
      RST = ($urandom % 400 == 0);
      clear = ($urandom % 90 == 0);
      tick = ($urandom % 3 == 0);
      fire_req = N_CH'($urandom) & N_CH'($urandom);
      for (int i = 0; i < N_CH; i++) set_enemy(i, 280 + int'($urandom % 80), int'($urandom % 512));
      player_x = X_W'(300 + $urandom % 40);
      player_y = Y_W'(100 + $urandom % 400);
      step();
      check_model();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
